// File: rtl/seq_multiplier_pkg.sv
// Shared constants for the sequential shift-add multiplier.
// State encodings, operand width, step limit and operand magnitude helper.
package seq_multiplier_pkg;

    localparam int MUL_WIDTH = 32;

    localparam logic [5:0] CNT_LIMIT = 6'd31;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [MUL_WIDTH-1:0] magnitude(
        input logic [MUL_WIDTH-1:0] v,
        input logic                 is_signed
    );
        // -2^31 maps to 0x80000000, which is correct as an unsigned magnitude
        if (is_signed && v[MUL_WIDTH-1])
            return ~v + 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/seq_multiplier_adder_n.sv
// Parameterised ripple-carry adder used for the shift-add step
// and for the final two's-complement negation.
module adder_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    logic [N-1:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential 32x32 multiplier: one shift-add step per cycle,
// 32 BUSY cycles, a single DONE cycle carrying the write strobe.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_signed,
    input  logic             op_hi,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             wr_en
);

    logic [1:0]         state;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic               sign_q;
    logic               hi_q;
    logic [4:0]         rd_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] neg_sum;
    logic [2*WIDTH-1:0] product;

    // Low half of acc holds the multiplier and is consumed LSB-first
    assign addend = acc[0] ? mcand : {WIDTH{1'b0}};

    adder_n #(
        .N(WIDTH + 1)
    ) u_step (
        .a  ({1'b0, acc[2*WIDTH-1:WIDTH]}),
        .b  ({1'b0, addend}),
        .cin(1'b0),
        .sum(step_sum)
    );

    assign acc_next = {step_sum, acc[WIDTH-1:1]};

    adder_n #(
        .N(2 * WIDTH)
    ) u_neg (
        .a  (~acc_next),
        .b  ({2*WIDTH{1'b0}}),
        .cin(1'b1),
        .sum(neg_sum)
    );

    assign product = sign_q ? neg_sum : acc_next;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            sign_q <= 1'b0;
            hi_q   <= 1'b0;
            rd_q   <= '0;
            result <= '0;
            rd_out <= '0;
            wr_en  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_BUSY;
                        cnt    <= '0;
                        acc    <= {{WIDTH{1'b0}},
                                   magnitude(src_b, op_signed)};
                        mcand  <= magnitude(src_a, op_signed);
                        sign_q <= op_signed
                                & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        hi_q   <= op_hi;
                        rd_q   <= rd_in;
                    end
                end
                S_BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == CNT_LIMIT) begin
                        state  <= S_DONE;
                        result <= hi_q ? product[2*WIDTH-1:WIDTH]
                                       : product[WIDTH-1:0];
                        rd_out <= rd_q;
                        wr_en  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier.
// Cycle 0 is the cycle start is driven; DONE is expected in cycle 33.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_signed;
    logic        op_hi;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wr_en;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seq_multiplier #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_signed(op_signed),
        .op_hi    (op_hi),
        .src_a    (src_a),
        .src_b    (src_b),
        .rd_in    (rd_in),
        .busy     (busy),
        .result   (result),
        .rd_out   (rd_out),
        .wr_en    (wr_en)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation and observes cycles 1..40; no checking here
    task automatic do_mul(
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic        sgn,
        input  logic        hi,
        input  logic [4:0]  rd,
        output int          wr_cyc,
        output int          wr_cnt,
        output logic [31:0] res,
        output logic [4:0]  rdo,
        output int          busy_bad
    );
        wr_cyc   = -1;
        wr_cnt   = 0;
        res      = 'x;
        rdo      = 'x;
        busy_bad = 0;
        start     = 1'b1;
        src_a     = a;
        src_b     = b;
        op_signed = sgn;
        op_hi     = hi;
        rd_in     = rd;
        tick();
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        rd_in = 5'($urandom);
        op_hi = ~hi;
        for (int c = 1; c <= 40; c++) begin
            if (wr_en) begin
                wr_cnt++;
                wr_cyc = c;
                res    = result;
                rdo    = rd_out;
            end
            if (c <= 33 && !busy) busy_bad++;
            if (c == 34 && busy) busy_bad++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        src_a = 32'd3;
        src_b = 32'd3;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        vectors++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_en got %b want 0", wr_en);
        end
        vectors++;
        if (result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result got %h want 0", result);
        end
        vectors++;
        if (rd_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_rd_out got %0d want 0", rd_out);
        end
        start = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_unsigned();
        int          cyc, cnt, bb;
        logic [31:0] r;
        logic [4:0]  d;
        do_mul(32'd7, 32'd6, 1'b0, 1'b0, 5'd5, cyc, cnt, r, d, bb);
        vectors++;
        if (cyc !== 33 || cnt !== 1) begin
            errors++;
            $display("FAIL u7x6_timing got cyc=%0d cnt=%0d want 33/1",
                     cyc, cnt);
        end
        vectors++;
        if (r !== 32'd42 || d !== 5'd5) begin
            errors++;
            $display("FAIL u7x6_result got %h rd=%0d want 2a rd=5", r, d);
        end
        vectors++;
        if (bb !== 0) begin
            errors++;
            $display("FAIL u7x6_busy got %0d bad cycles want 0", bb);
        end
        vectors++;
        if (result !== 32'd42 || rd_out !== 5'd5) begin
            errors++;
            $display("FAIL u7x6_hold got %h rd=%0d want 2a rd=5",
                     result, rd_out);
        end
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd9,
               cyc, cnt, r, d, bb);
        vectors++;
        if (r !== 32'hFFFFFFFE || cnt !== 1) begin
            errors++;
            $display("FAIL umax_hi got %h cnt=%0d want fffffffe", r, cnt);
        end
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd9,
               cyc, cnt, r, d, bb);
        vectors++;
        if (r !== 32'h00000001 || cnt !== 1) begin
            errors++;
            $display("FAIL umax_lo got %h cnt=%0d want 00000001", r, cnt);
        end
    endtask

    task automatic test_signed();
        int          cyc, cnt, bb;
        logic [31:0] r;
        logic [4:0]  d;
        do_mul(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 5'd1, cyc, cnt, r, d, bb);
        vectors++;
        if (r !== 32'hFFFFFFF1) begin
            errors++;
            $display("FAIL s_m3x5_lo got %h want fffffff1", r);
        end
        do_mul(32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 5'd1, cyc, cnt, r, d, bb);
        vectors++;
        if (r !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL s_m3x5_hi got %h want ffffffff", r);
        end
        do_mul(32'hFFFFFFFD, 32'd5, 1'b0, 1'b1, 5'd1, cyc, cnt, r, d, bb);
        vectors++;
        if (r !== 32'h00000004) begin
            errors++;
            $display("FAIL u_fffd_x5_hi got %h want 00000004", r);
        end
        do_mul(32'd6, 32'hFFFFFFF9, 1'b1, 1'b0, 5'd2, cyc, cnt, r, d, bb);
        vectors++;
        if (r !== 32'hFFFFFFD6) begin
            errors++;
            $display("FAIL s_6xm7_lo got %h want ffffffd6", r);
        end
        do_mul(32'h80000000, 32'h80000000, 1'b1, 1'b1, 5'd3,
               cyc, cnt, r, d, bb);
        vectors++;
        if (r !== 32'h40000000) begin
            errors++;
            $display("FAIL s_ovf_hi got %h want 40000000", r);
        end
        do_mul(32'h80000000, 32'h80000000, 1'b1, 1'b0, 5'd3,
               cyc, cnt, r, d, bb);
        vectors++;
        if (r !== 32'h00000000) begin
            errors++;
            $display("FAIL s_ovf_lo got %h want 00000000", r);
        end
    endtask

    task automatic test_rd_zero();
        int          cyc, cnt, bb;
        logic [31:0] r;
        logic [4:0]  d;
        do_mul(32'd12, 32'd10, 1'b0, 1'b0, 5'd0, cyc, cnt, r, d, bb);
        vectors++;
        if (cnt !== 1 || r !== 32'd120 || d !== 5'd0) begin
            errors++;
            $display("FAIL rd_zero got cnt=%0d r=%h rd=%0d want 1/78/0",
                     cnt, r, d);
        end
    endtask

    task automatic test_ignored_start();
        int          cnt = 0;
        int          cyc = -1;
        int          bb  = 0;
        logic [31:0] r   = 'x;
        start     = 1'b1;
        src_a     = 32'd2;
        src_b     = 32'd3;
        op_signed = 1'b0;
        op_hi     = 1'b0;
        rd_in     = 5'd7;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 10 || c == 33);
            src_a = 32'd9;
            src_b = 32'd9;
            if (wr_en) begin
                cnt++;
                cyc = c;
                r   = result;
            end
            if (c <= 33 && !busy) bb++;
            tick();
        end
        start = 1'b0;
        vectors++;
        if (cnt !== 1 || cyc !== 33) begin
            errors++;
            $display("FAIL ignored_start_wr got cnt=%0d cyc=%0d want 1/33",
                     cnt, cyc);
        end
        vectors++;
        if (r !== 32'd6) begin
            errors++;
            $display("FAIL ignored_start_result got %h want 6", r);
        end
        vectors++;
        if (bb !== 0) begin
            errors++;
            $display("FAIL ignored_start_busy got %0d bad want 0", bb);
        end
    endtask

    task automatic test_reset_midop();
        int          cyc, cnt, bb;
        int          seen = 0;
        logic [31:0] r;
        logic [4:0]  d;
        start     = 1'b1;
        src_a     = 32'd100;
        src_b     = 32'd100;
        op_signed = 1'b0;
        op_hi     = 1'b0;
        rd_in     = 5'd11;
        tick();
        start = 1'b0;
        for (int c = 1; c < 15; c++) begin
            if (wr_en) seen++;
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || seen !== 0) begin
            errors++;
            $display("FAIL midop_abort got busy=%b wr=%b seen=%0d want 0",
                     busy, wr_en, seen);
        end
        vectors++;
        if (result !== 32'd0 || rd_out !== 5'd0) begin
            errors++;
            $display("FAIL midop_outputs got %h rd=%0d want 0",
                     result, rd_out);
        end
        for (int c = 0; c < 40; c++) begin
            if (wr_en) seen++;
            tick();
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midop_late_wr got %0d strobes want 0", seen);
        end
        do_mul(32'd4, 32'd4, 1'b0, 1'b0, 5'd3, cyc, cnt, r, d, bb);
        vectors++;
        if (cyc !== 33 || r !== 32'd16 || d !== 5'd3) begin
            errors++;
            $display("FAIL midop_restart got cyc=%0d r=%h rd=%0d want 33/10/3",
                     cyc, r, d);
        end
    endtask

    task automatic test_back_to_back();
        int   w[3] = '{-1, -1, -1};
        int   n    = 0;
        int   adj  = 0;
        int   bad  = 0;
        logic prev = 1'b0;
        start     = 1'b1;
        src_a     = 32'd3;
        src_b     = 32'd11;
        op_signed = 1'b0;
        op_hi     = 1'b0;
        rd_in     = 5'd4;
        tick();
        for (int c = 1; c <= 110; c++) begin
            if (wr_en && prev) adj++;
            if (wr_en) begin
                if (n < 3) w[n] = c;
                if (result !== 32'd33) bad++;
                n++;
            end
            prev = wr_en;
            tick();
        end
        start = 1'b0;
        vectors++;
        if (w[0] !== 33 || w[1] !== 67 || w[2] !== 101) begin
            errors++;
            $display("FAIL b2b_spacing got %0d,%0d,%0d want 33,67,101",
                     w[0], w[1], w[2]);
        end
        vectors++;
        if (adj !== 0 || bad !== 0 || n !== 3) begin
            errors++;
            $display("FAIL b2b_strobes got adj=%0d bad=%0d n=%0d want 0/0/3",
                     adj, bad, n);
        end
        for (int c = 0; c < 50 && busy; c++) begin
            if (wr_en && prev) adj++;
            prev = wr_en;
            tick();
        end
        vectors++;
        if (busy !== 1'b0 || adj !== 0) begin
            errors++;
            $display("FAIL b2b_drain got busy=%b adj=%0d want 0/0",
                     busy, adj);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        op_signed = 1'b0;
        op_hi     = 1'b0;
        src_a     = '0;
        src_b     = '0;
        rd_in     = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_rd_zero();
        test_ignored_start();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
